double_lt_cmp: RTL and testbench

//   Streaming IEEE-754 binary64 "less than" comparator: z = (a < b).

---
 rtl/double_lt_cmp_if.sv | 9 +
 rtl/double_lt_cmp.sv | 52 +++++
 tb/tb_double_lt_cmp.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/double_lt_cmp_if.sv
// Operand/result bundle for the binary64 less-than comparator.
interface double_lt_cmp_if;
   logic [63:0] a;
   logic [63:0] b;
   logic        z;

   modport master (output a, output b, input  z);
   modport slave  (input  a, input  b, output z);
endinterface

// File: rtl/double_lt_cmp.sv
// Streaming IEEE-754 binary64 ordered compare: z = (a < b), one pair per clock,
// one-cycle registered latency.
module double_lt_cmp (
   input  logic           clk,
   input  logic           rst_n,
   double_lt_cmp_if.slave bus
);
   localparam int unsigned EXP_W  = 11;
   localparam int unsigned FRAC_W = 52;
   localparam int unsigned MAG_W  = 63;

   logic              sign_a, sign_b;
   logic [EXP_W-1:0]  exp_a, exp_b;
   logic [FRAC_W-1:0] frac_a, frac_b;
   logic [MAG_W-1:0]  mag_a, mag_b;
   logic              nan_a, nan_b;
   logic              both_zero;
   logic              z_d, z_q;

   // Field decode and ordering rules; infinities and denormals fall out of the magnitude compare.
   always_comb begin
      sign_a    = bus.a[63];
      sign_b    = bus.b[63];
      exp_a     = bus.a[62:52];
      exp_b     = bus.b[62:52];
      frac_a    = bus.a[51:0];
      frac_b    = bus.b[51:0];
      mag_a     = bus.a[62:0];
      mag_b     = bus.b[62:0];
      nan_a     = (exp_a == {EXP_W{1'b1}}) && (frac_a != '0);
      nan_b     = (exp_b == {EXP_W{1'b1}}) && (frac_b != '0);
      both_zero = (mag_a == '0) && (mag_b == '0);

      z_d = 1'b0;
      if (nan_a || nan_b || both_zero) begin
         z_d = 1'b0;
      end else if (sign_a != sign_b) begin
         z_d = sign_a;
      end else if (!sign_a) begin
         z_d = (mag_a < mag_b);
      end else begin
         z_d = (mag_a > mag_b);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) z_q <= 1'b0;
      else        z_q <= z_d;
   end

   assign bus.z = z_q;
endmodule

// File: tb/tb_double_lt_cmp.sv
// Directed-vector and reference-model bench for double_lt_cmp.
module tb_double_lt_cmp;
   logic clk;
   logic rst_n;
   int   n_cmp;
   int   n_bad;

   double_lt_cmp_if bus ();

   double_lt_cmp dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] a;
      logic [63:0] b;
      logic        z;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got z=%b want z=%b", name, act, exp);
      end
   endtask

   // Reference: map bit patterns onto an unsigned total-order key.
   function automatic logic ref_lt(input logic [63:0] a, input logic [63:0] b);
      logic [63:0] ka, kb;
      logic        a_nan, b_nan;
      a_nan = (a[62:52] == 11'h7FF) && (a[51:0] != 52'd0);
      b_nan = (b[62:52] == 11'h7FF) && (b[51:0] != 52'd0);
      if (a_nan || b_nan) return 1'b0;
      if (((a << 1) == 64'd0) && ((b << 1) == 64'd0)) return 1'b0;
      ka = a[63] ? ~a : (a | 64'h8000_0000_0000_0000);
      kb = b[63] ? ~b : (b | 64'h8000_0000_0000_0000);
      return ka < kb;
   endfunction

   function automatic logic [63:0] rand64();
      logic [63:0] v;
      int unsigned sel;
      v   = {$urandom(), $urandom()};
      sel = $urandom_range(0, 9);
      case (sel)
         0: v[62:52] = 11'h7FF;
         1: v[62:52] = 11'h000;
         2: v[62:0]  = 63'd0;
         3: v[51:0]  = 52'd0;
         default: ;
      endcase
      return v;
   endfunction

   task automatic drive(input logic [63:0] a, input logic [63:0] b);
      @(negedge clk);
      bus.a = a;
      bus.b = b;
   endtask

   initial begin
      logic [63:0] ra, rb;
      n_cmp = 0;
      n_bad = 0;

      vecs.push_back('{64'h3FF0000000000000, 64'h4000000000000000, 1'b1, "one_lt_two"});
      vecs.push_back('{64'h4000000000000000, 64'h3FF0000000000000, 1'b0, "two_lt_one"});
      vecs.push_back('{64'hC000000000000000, 64'hBFF0000000000000, 1'b1, "neg_two_lt_neg_one"});
      vecs.push_back('{64'hBFF0000000000000, 64'hC000000000000000, 1'b0, "neg_one_lt_neg_two"});
      vecs.push_back('{64'h8000000000000000, 64'h0000000000000000, 1'b0, "negzero_lt_zero"});
      vecs.push_back('{64'h0000000000000000, 64'h8000000000000000, 1'b0, "zero_lt_negzero"});
      vecs.push_back('{64'h3FF0000000000000, 64'h3FF0000000000000, 1'b0, "equal"});
      vecs.push_back('{64'h0000000000000000, 64'h0000000000000001, 1'b1, "zero_lt_min_denorm"});
      vecs.push_back('{64'h8000000000000001, 64'h0000000000000000, 1'b1, "neg_denorm_lt_zero"});
      vecs.push_back('{64'hFFF0000000000000, 64'hFFEFFFFFFFFFFFFF, 1'b1, "neginf_lt_negmax"});
      vecs.push_back('{64'h7FF0000000000000, 64'h7FF0000000000000, 1'b0, "posinf_lt_posinf"});
      vecs.push_back('{64'h7FEFFFFFFFFFFFFF, 64'h7FF0000000000000, 1'b1, "max_lt_posinf"});
      vecs.push_back('{64'hFFF0000000000000, 64'h7FF0000000000000, 1'b1, "neginf_lt_posinf"});
      vecs.push_back('{64'h7FF8000000000000, 64'h3FF0000000000000, 1'b0, "nan_lt_one"});
      vecs.push_back('{64'h3FF0000000000000, 64'h7FF8000000000000, 1'b0, "one_lt_nan"});
      vecs.push_back('{64'hFFF0000000000001, 64'h7FF0000000000000, 1'b0, "negnan_lt_inf"});
      vecs.push_back('{64'hBFF0000000000000, 64'h3FF0000000000000, 1'b1, "neg_lt_pos"});
      vecs.push_back('{64'h000FFFFFFFFFFFFF, 64'h0010000000000000, 1'b1, "max_denorm_lt_min_norm"});

      // Reset held with a pair that would yield 1.
      rst_n = 1'b0;
      bus.a = 64'hBFF0000000000000;
      bus.b = 64'h3FF0000000000000;
      repeat (3) @(posedge clk);
      #1 check("reset_hold", bus.z, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("reset_release_no_edge", bus.z, 1'b0);
      @(posedge clk);
      #1 check("first_after_reset", bus.z, 1'b1);

      // Directed table, back to back.
      foreach (vecs[i]) begin
         drive(vecs[i].a, vecs[i].b);
         @(posedge clk);
         #1 check(vecs[i].name, bus.z, vecs[i].z);
      end

      // Latency: z must not change before the sampling edge.
      drive(64'h3FF0000000000000, 64'h4000000000000000);
      @(posedge clk);
      drive(64'h4000000000000000, 64'h3FF0000000000000);
      #1 check("latency_hold_prev", bus.z, 1'b1);
      @(posedge clk);
      #1 check("latency_update", bus.z, 1'b0);

      // Mid-stream async reset discards in-flight result.
      drive(64'hC000000000000000, 64'h0000000000000000);
      @(posedge clk);
      #1 check("pre_midreset", bus.z, 1'b1);
      #2 rst_n = 1'b0;
      #1 check("midreset_async_clear", bus.z, 1'b0);
      @(posedge clk);
      #1 check("midreset_held", bus.z, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 check("midreset_first_after", bus.z, 1'b1);

      // Random stream against the reference model.
      for (int k = 0; k < 5000; k++) begin
         ra = rand64();
         rb = ($urandom_range(0, 15) == 0) ? ra : rand64();
         drive(ra, rb);
         @(posedge clk);
         #1;
         n_cmp++;
         if (bus.z !== ref_lt(ra, rb)) begin
            n_bad++;
            if (n_bad < 20)
               $display("FAIL random[%0d] a=%h b=%h: got z=%b want z=%b",
                        k, ra, rb, bus.z, ref_lt(ra, rb));
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
